// File: rtl/gate_seq_pkg.sv
// Shared definitions for the 2-input gate vector sequencer: FSM encoding,
// vector width and common truth tables indexed by {a,b}.
package gate_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int VEC_W = 2;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

  // Expected gate output for a given input vector.
  function automatic logic tt_expect(input logic [3:0] truth, input logic [VEC_W-1:0] vec);
    return truth[vec];
  endfunction

endpackage

// File: rtl/gate_vector_seq.sv
// Drives all four input vectors into a 2-input gate, holds each for a settle
// time, samples the gate output once per vector and counts mismatches.
module gate_vector_seq
  import gate_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter logic [3:0]  TRUTH       = TT_AND,
  parameter int unsigned PASSES      = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             gate_y,
  output logic             gate_a,
  output logic             gate_b,
  output logic [1:0]       vec_idx,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASSES - 1);
  localparam logic [CNT_W-1:0]  ERR_MAX   = '1;

  state_e             r_state;
  state_e             w_state_next;
  logic [VEC_W-1:0]   r_vec;
  logic [HOLD_W-1:0]  r_hold;
  logic [PASS_W-1:0]  r_pass_cnt;
  logic [CNT_W-1:0]   r_err;

  logic w_hold_last;
  logic w_last_vec;
  logic w_last_pass;
  logic w_mismatch;

  assign w_hold_last = (r_hold == HOLD_LAST);
  assign w_last_vec  = (r_vec == {VEC_W{1'b1}});
  assign w_last_pass = (r_pass_cnt == PASS_LAST);
  assign w_mismatch  = (gate_y != tt_expect(TRUTH, r_vec));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start) w_state_next = ST_DRIVE;
      ST_DRIVE:         if (w_hold_last) w_state_next = ST_SAMPLE;
      ST_SAMPLE:        w_state_next = (w_last_vec && w_last_pass) ? ST_DONE : ST_DRIVE;
      default:          w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == ST_DRIVE) || (r_state == ST_SAMPLE);
    done = (r_state == ST_DONE);
    pass = (r_state == ST_DONE) && (r_err == '0);
  end

  // The vector index rolls over naturally from 3 to 0, which also returns
  // the gate inputs to 00 on the way into DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec      <= '0;
      r_hold     <= '0;
      r_pass_cnt <= '0;
      r_err      <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_vec      <= '0;
            r_hold     <= '0;
            r_pass_cnt <= '0;
            r_err      <= '0;
          end
        end
        ST_DRIVE: begin
          r_hold <= w_hold_last ? '0 : r_hold + HOLD_W'(1);
        end
        ST_SAMPLE: begin
          if (w_mismatch && (r_err != ERR_MAX)) r_err <= r_err + CNT_W'(1);
          r_vec  <= r_vec + VEC_W'(1);
          r_hold <= '0;
          if (w_last_vec && !w_last_pass) r_pass_cnt <= r_pass_cnt + PASS_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign gate_a  = r_vec[1];
  assign gate_b  = r_vec[0];
  assign vec_idx = r_vec;
  assign err_cnt = r_err;

endmodule

// File: tb/tb_gate_vector_seq.sv
// Self-checking bench: a gate model with random faults and DRIVE-phase glitches
// feeds the sequencer; expected counts come from truth-table arithmetic.
module tb_gate_vector_seq;
  import gate_seq_pkg::*;

  localparam int H  = 4;
  localparam int N1 = 4 * (H + 1);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       start2;
  logic [3:0] tb_resp;
  logic       noise;
  logic       gate_y;

  logic       gate_a, gate_b, busy, done, pass;
  logic [1:0] vec_idx;
  logic [7:0] err_cnt;

  logic       p3_a, p3_b, p3_busy, p3_done, p3_pass;
  logic [1:0] p3_vec;
  logic [7:0] p3_err;

  logic       s_a, s_b, s_busy, s_done, s_pass;
  logic [1:0] s_vec;
  logic [1:0] s_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Gate under test model: arbitrary response table plus a glitch term.
  assign gate_y = tb_resp[{gate_a, gate_b}] ^ noise;

  gate_vector_seq #(.HOLD_CYCLES(H), .TRUTH(TT_AND), .PASSES(1), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_y(gate_y),
    .gate_a(gate_a), .gate_b(gate_b), .vec_idx(vec_idx), .busy(busy),
    .done(done), .pass(pass), .err_cnt(err_cnt)
  );

  gate_vector_seq #(.HOLD_CYCLES(4), .TRUTH(TT_AND), .PASSES(3), .CNT_W(8)) u_p3 (
    .clk(clk), .rst_n(rst_n), .start(start2), .gate_y(1'b1),
    .gate_a(p3_a), .gate_b(p3_b), .vec_idx(p3_vec), .busy(p3_busy),
    .done(p3_done), .pass(p3_pass), .err_cnt(p3_err)
  );

  gate_vector_seq #(.HOLD_CYCLES(2), .TRUTH(TT_AND), .PASSES(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .gate_y(1'b1),
    .gate_a(s_a), .gate_b(s_b), .vec_idx(s_vec), .busy(s_busy),
    .done(s_done), .pass(s_pass), .err_cnt(s_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full run on u_dut; optional ignored start pulses at cycles 3 and 10.
  task automatic run_main(input logic [3:0] resp, input bit poke);
    int expv;
    int ev;
    expv    = $countones(resp ^ TT_AND);
    tb_resp = resp;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < N1; c++) begin
      ev = (c / (H + 1)) % 4;
      chk("busy_run", 32'(busy), 32'd1);
      chk("vec_idx", 32'(vec_idx), 32'(ev));
      chk("gate_ab", 32'({gate_a, gate_b}), 32'(ev));
      if (c == 0) begin
        chk("done_drop", 32'(done), 32'd0);
        chk("err_clear", 32'(err_cnt), 32'd0);
      end
      start = poke && (c == 3 || c == 10);
      noise = ((c % (H + 1)) != H) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    noise = 1'b0;
    chk("done_at_20", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("err_cnt", 32'(err_cnt), 32'(expv));
    chk("pass", 32'(pass), 32'(expv == 0));
    chk("gate_ab_end", 32'({gate_a, gate_b}), 32'd0);
    repeat (3) @(negedge clk);
    chk("done_sticky", 32'(done), 32'd1);
    chk("err_sticky", 32'(err_cnt), 32'(expv));
    $display("run resp=%b poke=%0d err_cnt=%0d pass=%0d exp_err=%0d", resp, poke, err_cnt, pass, expv);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    start2  = 1'b0;
    noise   = 1'b0;
    tb_resp = TT_AND;
    repeat (3) @(negedge clk);
    chk("rst_gate_ab", 32'({gate_a, gate_b}), 32'd0);
    chk("rst_vec", 32'(vec_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    $display("reset checked");

    run_main(TT_AND, 1'b1);
    run_main(4'b0000, 1'b0);
    run_main(4'b1111, 1'b0);
    for (int r = 0; r < 5; r++) begin
      run_main(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    // Multi-pass (3 x 20 clocks) and saturation (2 x 12 clocks, 2-bit counter).
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    for (int c = 0; c < 60; c++) begin
      chk("p3_busy", 32'(p3_busy), 32'd1);
      chk("p3_done_early", 32'(p3_done), 32'd0);
      chk("sat_done", 32'(s_done), 32'(c >= 24));
      @(negedge clk);
    end
    chk("p3_done_at_60", 32'(p3_done), 32'd1);
    chk("p3_err", 32'(p3_err), 32'd9);
    chk("p3_pass", 32'(p3_pass), 32'd0);
    chk("sat_err", 32'(s_err), 32'd3);
    chk("sat_pass", 32'(s_pass), 32'd0);
    $display("multipass p3_err=%0d sat_err=%0d", p3_err, s_err);

    // Asynchronous reset in the middle of a run.
    tb_resp = 4'b1111;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_err", 32'(err_cnt), 32'd1);
    chk("mid_vec", 32'(vec_idx), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_gate_ab", 32'({gate_a, gate_b}), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_err", 32'(err_cnt), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);
    chk("post_rst_vec", 32'(vec_idx), 32'd0);
    $display("mid-run reset checked");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
